// File: rtl/aes_core_arbiter_pkg.sv
// Shared types for the two-requester masked AES core arbiter.
package aes_core_arbiter_pkg;

   localparam int NSHARES = 2;
   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RUN     = 2'd2,
      ST_DELIVER = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic any;
      logic winner;
   } rr_pick_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Client and core side buses of the arbiter; slave = arbiter, master = clients + core.
interface aes_core_arbiter_if
   import aes_core_arbiter_pkg::*;
#(
   parameter int d = NSHARES
);
   logic [NUM_REQ-1:0] req_valid_in;
   logic [NUM_REQ-1:0] req_in_ready;
   logic [NUM_REQ-1:0] req_inverse;
   logic [NUM_REQ-1:0] req_kso;
   logic [NUM_REQ-1:0] req_cipher_valid;
   logic [NUM_REQ-1:0] req_out_ready;
   logic [128*d-1:0]   req_sh_plaintext0;
   logic [128*d-1:0]   req_sh_plaintext1;
   logic [128*d-1:0]   req_sh_key0;
   logic [128*d-1:0]   req_sh_key1;
   logic [128*d-1:0]   req_sh_ciphertext0;
   logic [128*d-1:0]   req_sh_ciphertext1;

   logic               core_valid_in;
   logic               core_in_ready;
   logic               core_inverse;
   logic               core_kso;
   logic               core_cipher_valid;
   logic               core_out_ready;
   logic [128*d-1:0]   core_sh_plaintext;
   logic [128*d-1:0]   core_sh_key;
   logic [128*d-1:0]   core_sh_ciphertext;

   modport slave (
      input  req_valid_in, req_inverse, req_kso, req_out_ready,
      input  req_sh_plaintext0, req_sh_plaintext1, req_sh_key0, req_sh_key1,
      output req_in_ready, req_cipher_valid, req_sh_ciphertext0, req_sh_ciphertext1,
      input  core_in_ready, core_cipher_valid, core_sh_ciphertext,
      output core_valid_in, core_inverse, core_kso, core_out_ready,
      output core_sh_plaintext, core_sh_key
   );

   modport master (
      output req_valid_in, req_inverse, req_kso, req_out_ready,
      output req_sh_plaintext0, req_sh_plaintext1, req_sh_key0, req_sh_key1,
      input  req_in_ready, req_cipher_valid, req_sh_ciphertext0, req_sh_ciphertext1,
      output core_in_ready, core_cipher_valid, core_sh_ciphertext,
      input  core_valid_in, core_inverse, core_kso, core_out_ready,
      input  core_sh_plaintext, core_sh_key
   );

endinterface

// File: rtl/MSKcst.sv
// Masked constant: public value in share 0 of each bit, remaining shares zero.
module MSKcst #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic [count-1:0]   cst,
   output logic [count*d-1:0] out
);

   for (genvar i = 0; i < count; i++) begin : g_bit
      assign out[i*d] = cst[i];
      if (d > 1) begin : g_hi
         assign out[i*d+1 +: d-1] = '0;
      end
   end

endmodule

// File: rtl/MSKmux.sv
// Masked multiplexer: selects a whole sharing with a public select, shares untouched.
module MSKmux #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic               sel,
   input  logic [count*d-1:0] in_true,
   input  logic [count*d-1:0] in_false,
   output logic [count*d-1:0] out
);

   assign out = sel ? in_true : in_false;

endmodule

// File: rtl/aes_arb_rr_pick.sv
// Round-robin winner between two requesters; ties go to the one not served last.
module aes_arb_rr_pick
   import aes_core_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               last_owner,
   output rr_pick_t           pick
);

   always_comb begin
      pick.any    = |req_valid;
      pick.winner = (&req_valid) ? ~last_owner : req_valid[1];
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// Serializes whole masked AES operations of two clients onto one core.
// Optional AES_ARB_MODE_EN forwards per-client inverse/kso bits to the core.
module aes_core_arbiter
   import aes_core_arbiter_pkg::*;
#(
   parameter int d = NSHARES
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_core_arbiter_if.slave bus,
   output logic              core_rst,
   output logic              busy,
   output logic              owner
);

   localparam int W = 128 * d;

   arb_state_e       state, state_nxt;
   logic             owner_nxt;
   logic             last_owner, last_owner_nxt;
   logic [1:0]       rst_sync;
   rr_pick_t         pick;
   logic             in_grant, in_deliver;
   logic [1:0]       own_oh;
   logic [W-1:0]     zero_sh, pt_own, key_own;

   // Core reset leaves reset two edges after rst_n so the core sees a clean release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b11;
      else        rst_sync <= {rst_sync[0], 1'b0};
   end
   assign core_rst = rst_sync[1];

   aes_arb_rr_pick u_pick (
      .req_valid  (bus.req_valid_in),
      .last_owner (last_owner),
      .pick       (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      if (core_rst) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (pick.any) begin
               owner_nxt = pick.winner;
               state_nxt = ST_GRANT;
            end
            // A withdrawn request does not count as served.
            ST_GRANT: begin
               if (!bus.req_valid_in[owner]) state_nxt = ST_IDLE;
               else if (bus.core_in_ready)   state_nxt = ST_RUN;
            end
            ST_RUN: if (bus.core_cipher_valid) state_nxt = ST_DELIVER;
            ST_DELIVER: if (bus.core_cipher_valid && bus.req_out_ready[owner]) begin
               state_nxt      = ST_IDLE;
               last_owner_nxt = owner;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign in_grant   = (state == ST_GRANT);
   assign in_deliver = (state == ST_DELIVER);
   assign own_oh     = {owner, ~owner};
   assign busy       = (state != ST_IDLE);

   assign bus.core_valid_in    = in_grant & bus.req_valid_in[owner];
   assign bus.req_in_ready     = in_grant ? (own_oh & {2{bus.core_in_ready}}) : 2'b00;
   assign bus.req_cipher_valid = in_deliver ? (own_oh & {2{bus.core_cipher_valid}}) : 2'b00;
   assign bus.core_out_ready   = in_deliver & bus.req_out_ready[owner];

`ifdef AES_ARB_MODE_EN
   assign bus.core_inverse = in_grant & bus.req_inverse[owner];
   assign bus.core_kso     = in_grant & bus.req_kso[owner];
`else
   logic unused_mode;
   assign unused_mode      = ^{bus.req_inverse, bus.req_kso};
   assign bus.core_inverse = 1'b0;
   assign bus.core_kso     = 1'b0;
`endif

   // Sharings only ever pass through select gadgets; idle paths carry a zero sharing.
   MSKcst #(.d(d), .count(128)) u_zero (.cst(128'd0), .out(zero_sh));

   MSKmux #(.d(d), .count(128)) u_pt_own (
      .sel(owner), .in_true(bus.req_sh_plaintext1), .in_false(bus.req_sh_plaintext0), .out(pt_own));
   MSKmux #(.d(d), .count(128)) u_key_own (
      .sel(owner), .in_true(bus.req_sh_key1), .in_false(bus.req_sh_key0), .out(key_own));

   MSKmux #(.d(d), .count(128)) u_pt_core (
      .sel(in_grant), .in_true(pt_own), .in_false(zero_sh), .out(bus.core_sh_plaintext));
   MSKmux #(.d(d), .count(128)) u_key_core (
      .sel(in_grant), .in_true(key_own), .in_false(zero_sh), .out(bus.core_sh_key));

   MSKmux #(.d(d), .count(128)) u_ct0 (
      .sel(in_deliver & ~owner), .in_true(bus.core_sh_ciphertext), .in_false(zero_sh),
      .out(bus.req_sh_ciphertext0));
   MSKmux #(.d(d), .count(128)) u_ct1 (
      .sel(in_deliver & owner), .in_true(bus.core_sh_ciphertext), .in_false(zero_sh),
      .out(bus.req_sh_ciphertext1));

endmodule
